// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, bit-timing helper and acknowledge byte
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
  localparam logic [7:0] ACK_BYTE = 8'h06;
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 serialiser for a single byte, start pulse in, busy while shifting
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy
);
  localparam logic [15:0] BIT_M1 = 16'(CLKS_PER_BIT - 1);
  uart_state_t st;
  logic [15:0] cnt;
  logic [2:0]  idx;
  logic [7:0]  sh;
  logic        tick;
  assign tick = cnt == BIT_M1;
  assign busy = st != IDLE;
  always_ff @(posedge clock)
    if (rst) begin
      st  <= IDLE;
      tx  <= 1'b1;
      cnt <= '0;
      idx <= '0;
      sh  <= '0;
    end else begin
      cnt <= (st == IDLE || tick) ? '0 : cnt + 16'd1;
      case (st)
        IDLE:  if (start) begin st <= START; tx <= 1'b0; sh <= data; end
        START: if (tick) begin st <= DATA; tx <= sh[0]; sh <= sh >> 1; idx <= '0; end
        DATA:  if (tick) begin
          tx  <= idx == 3'd7 ? 1'b1 : sh[0];
          sh  <= sh >> 1;
          idx <= idx + 3'd1;
          if (idx == 3'd7) st <= STOP;
        end
        STOP:  if (tick) st <= IDLE;
      endcase
    end
endmodule

// File: rtl/uart_prog_loader.sv
// uart_prog_loader: receives 8N1 bytes, packs them little-endian into words on the upg_* write bus
module uart_prog_loader
  import uart_pkg::*;
#(
  parameter int         CLK_HZ         = 10_000_000,
  parameter int         BAUD           = 128_000,
  parameter int         CLKS_PER_BIT   = clks_per_bit(CLK_HZ, BAUD),
  parameter int         WORD_COUNT     = 32768,
  parameter int         TIMEOUT_CYCLES = 2_000_000,
  parameter logic [7:0] ACK_BYTE       = uart_pkg::ACK_BYTE
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        rx,
  output logic        tx,
  output logic [14:0] upg_adr_o,
  output logic [31:0] upg_dat_o,
  output logic        upg_wen_o,
  output logic        upg_done_o,
  output logic        frame_err_o
);
  localparam logic [15:0] BIT_M1   = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_M1  = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [14:0] LAST_ADR = 15'(WORD_COUNT - 1);
  localparam logic [31:0] TO_M1    = 32'(TIMEOUT_CYCLES - 1);
  logic        rx_m, rx_s, started, done_q, tx_busy, tx_start, byte_ok, bit_tick;
  uart_state_t rx_st;
  logic [15:0] cnt;
  logic [2:0]  idx;
  logic [7:0]  sh;
  logic [1:0]  k;
  logic [23:0] part;
  logic [31:0] idle;
  assign bit_tick = cnt == BIT_M1;
  assign byte_ok  = rx_st == STOP && bit_tick && rx_s && !upg_done_o;
  assign tx_start = upg_done_o && !done_q && !tx_busy;
  always_ff @(posedge clock)
    if (rst) begin
      rx_m        <= 1'b1;
      rx_s        <= 1'b1;
      rx_st       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      sh          <= '0;
      k           <= '0;
      part        <= '0;
      idle        <= '0;
      started     <= 1'b0;
      done_q      <= 1'b0;
      upg_adr_o   <= '0;
      upg_dat_o   <= '0;
      upg_wen_o   <= 1'b0;
      upg_done_o  <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      rx_m      <= rx;
      rx_s      <= rx_m;
      done_q    <= upg_done_o;
      upg_wen_o <= 1'b0;
      if (upg_done_o) rx_st <= IDLE;
      else case (rx_st)
        IDLE:  if (!rx_s) begin rx_st <= START; cnt <= '0; end
        START: begin
          cnt <= cnt == HALF_M1 ? '0 : cnt + 16'd1;
          idx <= '0;
          if (cnt == HALF_M1) rx_st <= rx_s ? IDLE : DATA;
        end
        DATA:  begin
          cnt <= bit_tick ? '0 : cnt + 16'd1;
          if (bit_tick) begin
            sh  <= {rx_s, sh[7:1]};
            idx <= idx + 3'd1;
            if (idx == 3'd7) rx_st <= STOP;
          end
        end
        STOP:  begin
          cnt <= bit_tick ? '0 : cnt + 16'd1;
          if (bit_tick) rx_st <= IDLE;
          if (bit_tick && !rx_s) frame_err_o <= 1'b1;
        end
      endcase
      if (byte_ok) begin
        started <= 1'b1;
        idle    <= '0;
        k       <= k + 2'd1;
        if (k == 2'd3) begin
          upg_dat_o <= {sh, part};
          upg_wen_o <= 1'b1;
        end else part[{k, 3'b000} +: 8] <= sh;
      end else if (started && !upg_done_o) idle <= idle + 32'd1;
      if (upg_wen_o) begin
        upg_adr_o <= upg_adr_o == LAST_ADR ? '0 : upg_adr_o + 15'd1;
        if (upg_adr_o == LAST_ADR) upg_done_o <= 1'b1;
      end
      // a short image ends here; any partially assembled word is dropped
      if (started && !upg_done_o && idle == TO_M1) begin
        upg_done_o <= 1'b1;
        k          <= '0;
      end
    end
  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clock(clock),
    .rst  (rst),
    .start(tx_start),
    .data (ACK_BYTE),
    .tx   (tx),
    .busy (tx_busy)
  );
endmodule

// File: tb/tb_uart_prog_loader.sv
// tb_uart_prog_loader: serial stimulus with a strobe scoreboard and ACK capture
module tb_uart_prog_loader;
  localparam int CPB = 8;
  logic        clock = 1'b0, rst = 1'b1, rx = 1'b1;
  logic        tx, upg_wen_o, upg_done_o, frame_err_o;
  logic [14:0] upg_adr_o;
  logic [31:0] upg_dat_o;
  int n_checks = 0, n_fail = 0;
  typedef struct packed { logic [14:0] adr; logic [31:0] dat; } exp_t;
  typedef struct { logic [31:0] word; logic [14:0] adr; } vec_t;
  exp_t sb[$];
  vec_t tbl[4];
  logic [7:0] ack_b;
  bit ack_ok;

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .WORD_COUNT(4), .TIMEOUT_CYCLES(400)) dut (
    .clock(clock), .rst(rst), .rx(rx), .tx(tx),
    .upg_adr_o(upg_adr_o), .upg_dat_o(upg_dat_o), .upg_wen_o(upg_wen_o),
    .upg_done_o(upg_done_o), .frame_err_o(frame_err_o)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  always @(negedge clock)
    if (!rst && upg_wen_o) begin
      exp_t e;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected strobe: got adr %h dat %h, want no strobe", upg_adr_o, upg_dat_o);
      end else begin
        e = sb.pop_front();
        check("strobe adr", 32'(upg_adr_o), 32'(e.adr));
        check("strobe dat", upg_dat_o, e.dat);
      end
    end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    wait_cycles(CPB);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
    send_bit(1'b1);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic expect_word(input int i);
    sb.push_back('{tbl[i].adr, tbl[i].word});
  endtask

  task automatic do_reset;
    rst = 1'b1;
    rx  = 1'b1;
    sb.delete();
    wait_cycles(3);
    rst = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, " tx"}, 32'(tx), 32'd1);
    check({tag, " adr"}, 32'(upg_adr_o), 32'd0);
    check({tag, " dat"}, upg_dat_o, 32'd0);
    check({tag, " wen"}, 32'(upg_wen_o), 32'd0);
    check({tag, " done"}, 32'(upg_done_o), 32'd0);
    check({tag, " ferr"}, 32'(frame_err_o), 32'd0);
  endtask

  task automatic capture_tx;
    int t = 0;
    ack_ok = 1'b0;
    ack_b  = '0;
    while (tx === 1'b1 && t < 2500) begin @(negedge clock); t++; end
    if (tx !== 1'b0) return;
    wait_cycles(CPB / 2);
    if (tx !== 1'b0) return;
    for (int i = 0; i < 8; i++) begin wait_cycles(CPB); ack_b[i] = tx; end
    wait_cycles(CPB);
    ack_ok = tx === 1'b1;
  endtask

  initial begin
    tbl[0] = '{32'h12345678, 15'd0};
    tbl[1] = '{32'hCAFEF00D, 15'd1};
    tbl[2] = '{32'h00FF00FF, 15'd2};
    tbl[3] = '{32'hA5A55A5A, 15'd3};

    // single word
    do_reset;
    check_reset("reset");
    expect_word(0);
    send_word(tbl[0].word);
    check("t1 pending", sb.size(), 0);
    check("t1 adr after", 32'(upg_adr_o), 32'd1);
    check("t1 done", 32'(upg_done_o), 32'd0);

    // full image, ACK on tx, nothing accepted afterwards
    do_reset;
    fork
      for (int i = 0; i < 4; i++) begin expect_word(i); send_word(tbl[i].word); end
      capture_tx;
    join
    check("t2 pending", sb.size(), 0);
    check("t2 done", 32'(upg_done_o), 32'd1);
    check("t2 adr wrap", 32'(upg_adr_o), 32'd0);
    check("t2 ack frame", 32'(ack_ok), 32'd1);
    check("t2 ack byte", 32'(ack_b), 32'h06);
    send_word(32'h11223344);
    check("t2 done sticky", 32'(upg_done_o), 32'd1);
    check("t2 adr held", 32'(upg_adr_o), 32'd0);
    check("t2 tx idle", 32'(tx), 32'd1);

    // short image ends by timeout, partial word dropped
    do_reset;
    expect_word(0);
    send_word(tbl[0].word);
    send_byte(8'h11);
    send_byte(8'h22);
    wait_cycles(380);
    check("t3 done early", 32'(upg_done_o), 32'd0);
    for (int t = 0; t < 100 && !upg_done_o; t++) wait_cycles(1);
    check("t3 done", 32'(upg_done_o), 32'd1);
    wait_cycles(5);
    check("t3 adr", 32'(upg_adr_o), 32'd1);
    check("t3 pending", sb.size(), 0);
    check("t3 dat", upg_dat_o, 32'h12345678);

    // framing error then a good word
    do_reset;
    sb.push_back('{15'd0, 32'hDDCCBBAA});
    send_byte(8'h55, 1'b0);
    check("t4 ferr", 32'(frame_err_o), 32'd1);
    send_word(32'hDDCCBBAA);
    check("t4 pending", sb.size(), 0);
    check("t4 adr", 32'(upg_adr_o), 32'd1);
    check("t4 ferr sticky", 32'(frame_err_o), 32'd1);

    // short glitch: no byte and no timeout
    do_reset;
    rx = 1'b0;
    wait_cycles(2);
    rx = 1'b1;
    wait_cycles(500);
    check("t5 done", 32'(upg_done_o), 32'd0);
    check("t5 ferr", 32'(frame_err_o), 32'd0);
    check("t5 adr", 32'(upg_adr_o), 32'd0);
    expect_word(1);
    sb[0].adr = 15'd0;
    send_word(tbl[1].word);
    check("t5 pending", sb.size(), 0);

    // reset mid-word and mid-byte
    do_reset;
    send_byte(8'hFF);
    send_byte(8'h00);
    rx = 1'b0;
    wait_cycles(20);
    rst = 1'b1;
    wait_cycles(1);
    check_reset("t6 in rst");
    do_reset;
    check_reset("t6 after");
    sb.push_back('{15'd0, tbl[3].word});
    send_word(tbl[3].word);
    check("t6 pending", sb.size(), 0);
    check("t6 adr", 32'(upg_adr_o), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at time limit, want finished");
    $fatal(1);
  end
endmodule
